// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for the single-ported data memory, with starvation-forced DMA priority.
module dmem_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_out
);
  typedef enum logic {CPU_PRI = 1'b0, DMA_PRI = 1'b1} state_t;
  localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);
  state_t        state_q, state_d;
  logic [7:0]    starve_q, starve_d;
  logic          cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic          cpu_gnt, dma_gnt, dma_denied;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= CPU_PRI;
    else        state_q <= state_d;
  always_comb
    state_d = (state_q == CPU_PRI) ? ((dma_denied && starve_q == LIMIT_M1) ? DMA_PRI : CPU_PRI)
                                   : ((dma_gnt || !dma_req) ? CPU_PRI : DMA_PRI);
  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    cpu_gnt    = rst_n & cpu_req & ~((state_q == DMA_PRI) & dma_req);
    dma_gnt    = rst_n & dma_req & ~cpu_gnt;
    dma_denied = dma_req & ~dma_gnt;
    cpu_stall  = cpu_req & ~cpu_gnt;
    mem_addr   = cpu_gnt ? cpu_addr  : dma_gnt ? dma_addr  : '0;
    mem_in     = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    mem_wr     = cpu_gnt ? cpu_we    : dma_gnt & dma_we;
  end
  always_comb begin
    starve_d    = dma_denied ? ((starve_q == 8'hFF) ? starve_q : starve_q + 8'd1) : 8'd0;
    cpu_ack_d   = cpu_gnt;
    dma_ack_d   = dma_gnt;
    cpu_rdata_d = (cpu_gnt & ~cpu_we) ? mem_out : cpu_rdata_q;
    dma_rdata_d = (dma_gnt & ~dma_we) ? mem_out : dma_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      starve_q    <= 8'd0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
endmodule
